// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
//   Sequencer that feeds a wide operand pair, one nibble per cycle (LSB
//   nibble first), into an external combinational 4-bit adder. The carry is
//   registered between nibbles, and the assembled sum plus the final carry
//   are returned over a valid/ready handshake.
//
//   Optional build macro: SUBTRACT_EN. When defined, adds input port `sub`.
//   sub=1 computes op_a - op_b as op_a + ~op_b + 1. In that case c_out=1
//   means no borrow occurred.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (op_a, op_b, c_in[, sub])
//   add_a/add_b/add_cin nibble and carry driven to the external adder
//   add_s/add_cout      combinational result returned by the adder
//   out_valid/out_ready result handshake (sum, c_out)
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W      = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         c_in,
`ifdef SUBTRACT_EN
    input  logic         sub,
`endif
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_cin,
    input  logic [3:0]   add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [W-1:0]  res_q, res_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;
        sum       = '0;
        c_out     = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_sh_d  = op_a;
                    b_sh_d  = op_b;
                    carry_d = c_in;
`ifdef SUBTRACT_EN
                    // Two's-complement subtract: invert B and force carry-in.
                    if (sub) begin
                        b_sh_d  = ~op_b;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                add_a   = a_sh_q[3:0];
                add_b   = b_sh_q[3:0];
                add_cin = carry_q;
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                carry_d = add_cout;
                // Result fills from the top; after NIBBLES shifts the first
                // captured nibble lands in bits [3:0].
                res_d          = res_q >> 4;
                res_d[W-1 -: 4] = add_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                sum       = res_q;
                c_out     = carry_q;
                if (out_ready) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//   Directed bench for nibble_serial_add_ctrl (NIBBLES=4). The external 4-bit
//   adder is modelled combinationally here. Inputs are driven and outputs are
//   sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic [3:0]   add_a, add_b, add_s;
    logic         add_cin, add_cout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;

    always #5 clk = ~clk;

    // External 4-bit ripple adder stage.
    always_comb {add_cout, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .c_in(c_in),
`ifdef SUBTRACT_EN
        .sub(sub),
`endif
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sb;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vt[10];
    int   nv;

    // Runs one operation end to end. Returns sum/c_out as seen in DONE,
    // the number of RUN cycles before out_valid, and the nibble streams
    // driven to the adder (first nibble ends up in bits [3:0]).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb,
                         output logic [W-1:0] s, output logic co,
                         output int lat, output logic [W-1:0] aseq,
                         output logic [W-1:0] bseq);
        int t;
        aseq = '0; bseq = '0; lat = 0; s = '0; co = 1'b0;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        op_a = a; op_b = b; c_in = ci; sub = sb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            aseq = {add_a, aseq[W-1:4]};
            bseq = {add_b, bseq[W-1:4]};
            lat++;
            @(negedge clk);
        end
        s  = sum;
        co = c_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] s, aseq, bseq;
        logic         co;
        int           lat;

        nv = 0;
        vt[nv++] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
        vt[nv++] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
        vt[nv++] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        vt[nv++] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};
        vt[nv++] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1};
        vt[nv++] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0};
        vt[nv++] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0};
`ifdef SUBTRACT_EN
        vt[nv++] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0};
        vt[nv++] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1};
        vt[nv++] = '{16'h0007, 16'h0005, 1'b0, 1'b0, 16'h000C, 1'b0};
`endif

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Table-driven vectors
        for (int i = 0; i < nv; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].sb, s, co, lat, aseq, bseq);
            chk($sformatf("v%0d_sum", i), 32'(s), 32'(vt[i].s));
            chk($sformatf("v%0d_cout", i), 32'(co), 32'(vt[i].co));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(N));
            chk($sformatf("v%0d_aseq", i), 32'(aseq), 32'(vt[i].a));
            chk($sformatf("v%0d_bseq", i), 32'(bseq),
                32'(vt[i].sb ? ~vt[i].b : vt[i].b));
        end

        // Backpressure in DONE with a new request pulsed
        @(negedge clk);
        op_a = 16'h1111; op_b = 16'h2222; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (N) @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            op_a = 16'h5555; op_b = 16'h5555; in_valid = (i % 2 == 0);
            @(negedge clk);
            chk("bp_hold_sum", 32'(sum), 32'h3333);
            chk("bp_hold_cout", 32'(c_out), 32'd0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, s, co, lat, aseq, bseq);
        chk("bp_next_sum", 32'(s), 32'h0003);
        chk("bp_next_latency", 32'(lat), 32'(N));

        // Reset asserted during RUN at cnt=2
        @(negedge clk);
        op_a = 16'h5678; op_b = 16'h1111; c_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_run_add_a", 32'(add_a), 32'h6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sum", 32'(sum), 32'd0);
        chk("mid_rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, lat, aseq, bseq);
        chk("post_rst_sum", 32'(s), 32'h0002);
        chk("post_rst_cout", 32'(co), 32'd0);

        // out_ready outside DONE is ignored
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        do_op(16'h00F0, 16'h0010, 1'b0, 1'b0, s, co, lat, aseq, bseq);
        chk("oready_idle_sum", 32'(s), 32'h0100);
        chk("oready_idle_latency", 32'(lat), 32'(N));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Upstream sequencer for the team's 4-bit ripple-carry adder stage. It accepts two wide operands over a valid/ready handshake and feeds them one nibble per cycle, LSB nibble first, into an external 4-bit adder. Carry is registered between nibbles, and the assembled wide sum and final carry are returned over a second valid/ready handshake. The controller lets one 4-bit adder instance serve operands of any multiple-of-4 width.

Parameters:
NIBBLES, 4, operand width in nibbles; W = 4*NIBBLES bits (default 16); legal range 1..16

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand pair and c_in are valid
in_ready  output  1  controller can accept an operand pair
op_a  input  W  operand A
op_b  input  W  operand B
c_in  input  1  initial carry-in
add_a  output  4  nibble to adder A input
add_b  output  4  nibble to adder B input
add_cin  output  1  carry to adder C_in
add_s  input  4  adder S result (combinational return)
add_cout  input  1  adder C_out (combinational return)
out_valid  output  1  sum and c_out valid
out_ready  input  1  downstream accepts result
sum  output  W  wide sum
c_out  output  1  final carry-out

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, cnt=0, carry reg=0, operand and result shift registers=0.
  - in_ready=1 (once rst_n is high), out_valid=0, sum=0, c_out=0, add_a=add_b=0, add_cin=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; add_* driven 0.
  - On in_valid&in_ready: latch op_a and op_b into shift regs, carry<=c_in, cnt<=0, go to RUN.
- RUN:
  - in_ready=0. add_a=a_sh[3:0], add_b=b_sh[3:0], add_cin=carry.
  - Each cycle: result reg shifts right 4 with add_s entering bits [W-1:W-4]; carry<=add_cout; a_sh and b_sh shift right 4; cnt++.
  - When cnt==NIBBLES-1, that cycle's capture is the last; go to DONE.
- DONE:
  - out_valid=1; sum=result reg; c_out=carry; in_ready=0.
  - Outputs hold stable while out_ready=0.
  - On out_ready: out_valid drops next cycle, go to IDLE.
- Latency: handshake accepted at edge k gives out_valid high after edge k+NIBBLES. Throughput is one operation per NIBBLES+2 cycles; there is one IDLE bubble between results.
- Width: the sum is mod 2^W and the carry out of the top nibble is c_out. No overflow flag.
- NIBBLES=1: exactly one RUN cycle.
- in_valid outside IDLE is ignored; the upstream source must hold its data until in_ready.
- Reset mid-RUN or mid-DONE aborts immediately to the reset values. No partial result is emitted.
- out_ready asserted outside DONE has no effect.

Optional Feature:
SUBTRACT_EN
- Defined: adds input port sub (1 bit), sampled with the operands. When sub=1:
  - b_sh loads ~op_b.
  - carry loads 1; c_in is ignored.
  - The result is op_a-op_b mod 2^W; c_out=1 means no borrow.
  - sub=0 behaves exactly as addition.
- Undefined: no sub port; the block only adds.

Test Plan:
1. NIBBLES=4: op_a=0x1234, op_b=0x4321, c_in=0 -> out_valid 4 cycles after accept; sum=0x5555, c_out=0; add_a sequence 4,3,2,1.
2. 0xFFFF+0x0001, c_in=0 -> carry propagates through all 4 nibble cycles; sum=0x0000, c_out=1.
3. 0xFFFF+0xFFFF, c_in=1 -> sum=0xFFFF, c_out=1.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new data -> sum and c_out unchanged, in_ready=0, new data not accepted. Raise out_ready -> IDLE, then the next operation is accepted.
5. Assert rst_n=0 during RUN at cnt=2 -> out_valid=0, sum=0, add_*=0 immediately; after release, in_ready=1 and the next operation 0x0001+0x0001 gives 0x0002.
6. SUBTRACT_EN defined: 0x0005-0x0007 (sub=1) -> sum=0xFFFE, c_out=0; 0x0007-0x0005 -> sum=0x0002, c_out=1.
